// File: rtl/sphere_pkg.sv
// sphere_pkg: shared definitions for the ray-sphere discriminant stage.
//   W          - width of coordinate, radius, B, root and distance fields
//   FRAC_BITS  - fraction bits of the Q2.14 direction components
//   SQRT_ITERS - result bits produced by the iterative square root
//   state_t    - FSM state encoding (ROUND is only reachable when
//                SPHERE_ROOT_ROUND_EN is defined)
//   sat_w()    - saturate a wide signed value into the signed W range
package sphere_pkg;

  localparam int W          = 16;
  localparam int FRAC_BITS  = 14;
  localparam int SQRT_ITERS = 16;

  localparam int SAT_MAX = (2 ** (W - 1)) - 1;
  localparam int SAT_MIN = -(2 ** (W - 1));

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MUL   = 3'd1,
    DISC  = 3'd2,
    SQRT  = 3'd3,
    ROUND = 3'd4,
    OUT   = 3'd5
  } state_t;

  function automatic logic signed [W-1:0] sat_w(input logic signed [35:0] v);
    if (v > 36'(SAT_MAX))
      return {1'b0, {(W-1){1'b1}}};
    else if (v < 36'(SAT_MIN))
      return {1'b1, {(W-1){1'b0}}};
    else
      return v[W-1:0];
  endfunction

endpackage

// File: rtl/isqrt_iter.sv
// isqrt_iter: non-restoring bit-pair integer square root, one result bit
// per cycle, MSB first, SQRT_ITERS cycles in total.
//   CLK       - clock, rising edge
//   aresetn   - asynchronous active-low reset; aborts any running root
//   start     - load radicand; the first iteration happens on this edge
//   radicand  - 32-bit unsigned input, sampled when start=1
//   busy      - iterations still outstanding
//   done      - one-cycle pulse once root holds floor(sqrt(radicand))
//   root      - 16-bit result
module isqrt_iter
  import sphere_pkg::*;
(
  input  logic        CLK,
  input  logic        aresetn,
  input  logic        start,
  input  logic [31:0] radicand,
  output logic        busy,
  output logic        done,
  output logic [15:0] root
);

  // Signed partial remainder; 20 bits covers the worst-case swing of the
  // last iteration (|rem| < 2^19).
  logic signed [19:0] rem_q;
  logic        [31:0] rad_q;
  logic        [3:0]  cnt_q;

  logic signed [19:0] rem_s, rem_n;
  logic        [15:0] root_s, root_n;
  logic        [31:0] rad_s, rad_n;

  // The start edge performs the first iteration on the fresh radicand so
  // that all SQRT_ITERS iterations fit between start and done.
  always_comb begin
    rem_s  = rem_q;
    root_s = root;
    rad_s  = rad_q;
    if (start) begin
      rem_s  = '0;
      root_s = '0;
      rad_s  = radicand;
    end
    // A negative remainder is not restored; the next step adds instead.
    if (!rem_s[19])
      rem_n = (rem_s <<< 2) + $signed({18'd0, rad_s[31:30]})
              - $signed({2'b00, root_s, 2'b01});
    else
      rem_n = (rem_s <<< 2) + $signed({18'd0, rad_s[31:30]})
              + $signed({2'b00, root_s, 2'b11});
    root_n = {root_s[14:0], ~rem_n[19]};
    rad_n  = {rad_s[29:0], 2'b00};
  end

  always_ff @(posedge CLK or negedge aresetn) begin
    if (!aresetn) begin
      rem_q <= '0;
      rad_q <= '0;
      cnt_q <= '0;
      root  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem_q <= rem_n;
        rad_q <= rad_n;
        root  <= root_n;
        cnt_q <= 4'd1;
        busy  <= 1'b1;
      end else if (busy) begin
        rem_q <= rem_n;
        rad_q <= rad_n;
        root  <= root_n;
        cnt_q <= cnt_q + 4'd1;
        if (cnt_q == 4'(SQRT_ITERS - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sphere_discriminant.sv
// sphere_discriminant: upstream stage of the ray-sphere distance calculation.
// Computes B = 2*dot(Oc,Dir) (saturated), QuickIntersects = (disc >= 0) and
// RootDiscriminant = isqrt(B^2 - 4*(Oc.Oc - R^2)), 0 on a miss.
// Optional build macro: SPHERE_ROOT_ROUND_EN adds a ROUND state that rounds
// the root to nearest (one extra cycle on hits).
//   CLK, aresetn              - clock, asynchronous active-low reset
//   OcX/OcY/OcZ               - signed ray origin minus sphere centre
//   DirX/DirY/DirZ            - signed unit direction, Q2.14
//   Radius, OldDistanceIn     - unsigned radius, closest hit (passed through)
//   InputValid / InputReady   - input handshake
//   B, RootDiscriminant, QuickIntersects, OldDistance - registered results
//   OutputValid / OutReady    - output handshake
//   DbgState                  - {isqrt busy, FSM state} for observation
// Handshake: a pair transfers on a rising edge where InputValid and
// InputReady are both 1 (InputReady is 1 only in IDLE); a result transfers
// on a rising edge where OutputValid and OutReady are both 1, and results
// stay stable while OutputValid=1 and OutReady=0.
module sphere_discriminant
  import sphere_pkg::*;
(
  input  logic                CLK,
  input  logic                aresetn,
  input  logic signed [W-1:0] OcX,
  input  logic signed [W-1:0] OcY,
  input  logic signed [W-1:0] OcZ,
  input  logic signed [W-1:0] DirX,
  input  logic signed [W-1:0] DirY,
  input  logic signed [W-1:0] DirZ,
  input  logic        [W-1:0] Radius,
  input  logic        [W-1:0] OldDistanceIn,
  input  logic                InputValid,
  output logic                InputReady,
  output logic signed [W-1:0] B,
  output logic        [W-1:0] RootDiscriminant,
  output logic                QuickIntersects,
  output logic        [W-1:0] OldDistance,
  output logic                OutputValid,
  input  logic                OutReady,
  output logic        [3:0]   DbgState
);

  state_t state;

  logic signed [W-1:0] ocx_q, ocy_q, ocz_q, dirx_q, diry_q, dirz_q;
  logic        [W-1:0] rad_q, old_q;
  logic signed [33:0]  ocd_q;
  logic        [33:0]  ococ_q;
  logic        [31:0]  r2_q;
  logic signed [W-1:0] b_q;

  logic signed [33:0]  ocd_n;
  logic        [33:0]  ococ_n;
  logic        [31:0]  r2_n;
  logic signed [19:0]  dot;
  logic signed [35:0]  b_wide, c_val, b_sq, disc_val;
  logic signed [W-1:0] b_sat;
  logic                disc_neg;
  logic        [31:0]  disc_clamp;

  logic        sq_start, sq_busy, sq_done;
  logic [15:0] sq_root;

  always_comb begin
    ocd_n  = 34'(ocx_q) * 34'(dirx_q) + 34'(ocy_q) * 34'(diry_q)
           + 34'(ocz_q) * 34'(dirz_q);
    ococ_n = 34'(34'(ocx_q) * 34'(ocx_q) + 34'(ocy_q) * 34'(ocy_q)
           + 34'(ocz_q) * 34'(ocz_q));
    r2_n   = 32'(rad_q) * 32'(rad_q);

    dot      = 20'(ocd_q >>> FRAC_BITS);
    b_wide   = 36'(dot) <<< 1;
    b_sat    = sat_w(b_wide);
    c_val    = $signed({2'b00, ococ_q}) - $signed({4'b0000, r2_q});
    // The saturated B feeds the discriminant, matching what leaves the block.
    b_sq     = 36'(b_sat) * 36'(b_sat);
    disc_val = b_sq - (c_val <<< 2);
    disc_neg = disc_val[35];
    disc_clamp = (disc_val > 36'sh0_FFFF_FFFF) ? 32'hFFFF_FFFF : disc_val[31:0];
  end

  assign sq_start = (state == DISC) && !disc_neg;
  assign DbgState = {sq_busy, state};

  isqrt_iter u_isqrt (
    .CLK      (CLK),
    .aresetn  (aresetn),
    .start    (sq_start),
    .radicand (disc_clamp),
    .busy     (sq_busy),
    .done     (sq_done),
    .root     (sq_root)
  );

`ifdef SPHERE_ROOT_ROUND_EN
  logic [31:0] disc_q;
  logic [15:0] root_q;
  logic [32:0] rem_sq;
  logic [15:0] rnd_root;

  // Round to nearest: bump when the remainder exceeds root, i.e. when
  // disc >= (root + 0.5)^2 for integer disc.
  always_comb begin
    rem_sq   = {1'b0, disc_q} - 33'(root_q) * 33'(root_q);
    rnd_root = root_q;
    if ((rem_sq > 33'(root_q)) && (root_q != 16'hFFFF))
      rnd_root = root_q + 16'd1;
  end
`endif

  always_ff @(posedge CLK or negedge aresetn) begin
    if (!aresetn) begin
      state            <= IDLE;
      InputReady       <= 1'b0;
      OutputValid      <= 1'b0;
      B                <= '0;
      RootDiscriminant <= '0;
      QuickIntersects  <= 1'b0;
      OldDistance      <= '0;
      ocx_q  <= '0;
      ocy_q  <= '0;
      ocz_q  <= '0;
      dirx_q <= '0;
      diry_q <= '0;
      dirz_q <= '0;
      rad_q  <= '0;
      old_q  <= '0;
      ocd_q  <= '0;
      ococ_q <= '0;
      r2_q   <= '0;
      b_q    <= '0;
`ifdef SPHERE_ROOT_ROUND_EN
      disc_q <= '0;
      root_q <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          InputReady <= 1'b1;
          if (InputValid && InputReady) begin
            ocx_q      <= OcX;
            ocy_q      <= OcY;
            ocz_q      <= OcZ;
            dirx_q     <= DirX;
            diry_q     <= DirY;
            dirz_q     <= DirZ;
            rad_q      <= Radius;
            old_q      <= OldDistanceIn;
            InputReady <= 1'b0;
            state      <= MUL;
          end
        end
        MUL: begin
          ocd_q  <= ocd_n;
          ococ_q <= ococ_n;
          r2_q   <= r2_n;
          state  <= DISC;
        end
        DISC: begin
          b_q <= b_sat;
          if (disc_neg) begin
            B                <= b_sat;
            RootDiscriminant <= '0;
            QuickIntersects  <= 1'b0;
            OldDistance      <= old_q;
            OutputValid      <= 1'b1;
            state            <= OUT;
          end else begin
`ifdef SPHERE_ROOT_ROUND_EN
            disc_q <= disc_clamp;
`endif
            state <= SQRT;
          end
        end
        SQRT: begin
          if (sq_done) begin
`ifdef SPHERE_ROOT_ROUND_EN
            root_q <= sq_root;
            state  <= ROUND;
`else
            B                <= b_q;
            RootDiscriminant <= sq_root;
            QuickIntersects  <= 1'b1;
            OldDistance      <= old_q;
            OutputValid      <= 1'b1;
            state            <= OUT;
`endif
          end
        end
`ifdef SPHERE_ROOT_ROUND_EN
        ROUND: begin
          B                <= b_q;
          RootDiscriminant <= rnd_root;
          QuickIntersects  <= 1'b1;
          OldDistance      <= old_q;
          OutputValid      <= 1'b1;
          state            <= OUT;
        end
`endif
        OUT: begin
          if (OutReady) begin
            OutputValid <= 1'b0;
            InputReady  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/sphere_discriminant.md
Name: sphere_discriminant

Overview:
- Upstream stage of the ray-sphere distance calculation. Computes B and QuickIntersects from the ray-to-centre offset, unit ray direction and sphere radius.
- Also computes RootDiscriminant with an iterative integer square root.
- Feeds the distance-calculation stage directly: B, RootDiscriminant, QuickIntersects and OldDistance map one-to-one onto that stage's inputs, via a valid/ready handshake.

Parameters:
- W, 16: width of the coordinate, radius, B, root and distance fields.
- FRAC_BITS, 14: fraction bits of the direction components (Q2.14, so 1.0 = 16384).

Ports:
- CLK  in  1  clock; all state updates on the rising edge
- aresetn  in  1  reset, asynchronous assert, active-low
- OcX, OcY, OcZ  in  W each, signed  ray origin minus sphere centre, integer units
- DirX, DirY, DirZ  in  W each, signed  unit ray direction, Q2.14
- Radius  in  W, unsigned  sphere radius
- OldDistanceIn  in  W  current closest hit, passed through
- InputValid  in  1  upstream offers a ray/sphere pair
- InputReady  out  1  block can accept a pair
- B  out  W, signed  2*dot(Oc,Dir), saturated
- RootDiscriminant  out  W  isqrt(B^2 - 4c); 0 on miss
- QuickIntersects  out  1  discriminant >= 0
- OldDistance  out  W  registered copy of OldDistanceIn
- OutputValid  out  1  result held, waiting for downstream
- OutReady  in  1  downstream accepts (tied to the downstream InputReady)

Behaviour:
- States: IDLE -> MUL -> DISC -> SQRT (16 cycles) -> OUT -> IDLE.
- Reset (async, aresetn=0), all outputs and state:
  - state=IDLE; InputReady=1 once reset is released.
  - OutputValid=0, B=0, RootDiscriminant=0, QuickIntersects=0, OldDistance=0.
- IDLE:
  - InputReady=1.
  - On InputValid=1, register all inputs and go to MUL.
- MUL:
  - Register OcD = OcX*DirX + OcY*DirY + OcZ*DirZ (signed, 34 bits).
  - Register OcOc = sum of squares (unsigned, 34 bits).
  - Register R2 = Radius^2.
- DISC:
  - dot = OcD >>> FRAC_BITS (arithmetic shift).
  - B = 2*dot, saturated to the signed W range [-32768, 32767].
  - c = OcOc - R2, signed 36-bit.
  - disc = B*B - 4*c, signed 36-bit, using the saturated B.
  - If disc < 0: QuickIntersects=0, RootDiscriminant=0, go to OUT.
  - Otherwise: QuickIntersects=1; clamp disc to 0xFFFF_FFFF; start isqrt; go to SQRT.
- SQRT:
  - Non-restoring bit-pair square root, one result bit per cycle, MSB first, 16 cycles.
  - Result is floor(sqrt(disc)), at most 65535.
- OUT:
  - OutputValid=1; B, RootDiscriminant, QuickIntersects and OldDistance held stable.
  - Leave for IDLE on the edge where OutReady=1.
  - No new input is accepted in the same cycle (InputReady=0 outside IDLE).
- Latency, counted in edges from the accept edge to OutputValid=1:
  - 19 when disc >= 0.
  - 3 when disc < 0.
  - Throughput is one pair per latency+1 cycles or more.
- Backpressure: OutReady low holds OUT indefinitely; outputs must not change.
- Boundaries:
  - disc = 0 is tangent: QuickIntersects=1, root=0.
  - InputValid while not in IDLE is ignored and the input is not consumed.
  - Reset asserted mid-SQRT or in OUT aborts immediately: OutputValid=0 asynchronously, partial root discarded.

Optional Feature:
- Macro SPHERE_ROOT_ROUND_EN.
- Defined: after the 16 iterations, one extra cycle in state ROUND.
  - If disc - root^2 > root, root += 1; saturate at 65535.
  - Latency for disc >= 0 becomes 20.
- Undefined: floor root, no ROUND state, latency 19.

Decomposition:
- Package sphere_pkg holds:
  - the state enum (IDLE, MUL, DISC, SQRT, ROUND, OUT);
  - the constants W, FRAC_BITS and SQRT_ITERS=16;
  - a saturate-to-W function.
- One sub-module, isqrt_iter:
  - ports: CLK, aresetn, start, 32-bit radicand, busy, done, 16-bit root;
  - internal iteration counter;
  - done pulses for one cycle.
  - The FSM waits in SQRT until done.

Test Plan:
- Hit on axis: Oc=(0,0,-10), Dir=(0,0,16384), R=3, OldDistanceIn=100.
  - Expect B=-20, disc=36, RootDiscriminant=6, QuickIntersects=1, OldDistance=100.
  - OutputValid exactly 19 edges after accept.
- Miss: Oc=(10,0,-10), same Dir, R=3.
  - Expect disc=-364, QuickIntersects=0, root=0, B=-20, OutputValid after 3 edges.
- Tangent: Oc=(3,0,-10), R=3.
  - Expect disc=0, QuickIntersects=1, root=0.
- Non-square: Oc=(1,0,-10), R=4.
  - Expect disc=60, root=7.
  - With SPHERE_ROOT_ROUND_EN: root=8, latency 20.
- Backpressure plus stale input: hold OutReady=0 for 5 cycles in OUT with InputValid=1 and a different pair.
  - Outputs stable and InputReady=0 throughout.
  - After OutReady=1, the next pair is accepted only from IDLE.
- Reset mid-SQRT: assert aresetn=0 at iteration 8.
  - OutputValid=0 and all outputs 0 without waiting for a clock edge.
  - After release, the next pair (the hit-on-axis case) produces the correct result.
